// File: rtl/ieu_muldiv_seq.sv
// ieu_muldiv_seq
// Multi-cycle sequencer for the RV32M multiply/divide operations in the
// execute stage. An op is accepted from decode with forwarded operands, the
// pipeline is stalled while the op is worked on, and the result is presented
// with a one-cycle strobe towards write-back.
//   Multiply ops take one registered pass through a full-width multiplier.
//   Divide/remainder ops use an iterative restoring divider, one bit per cycle.
//   Divide-by-zero and signed overflow finish without iterating.
//
// Ports:
//   brq_clk          clock
//   brq_rst          asynchronous, active-high reset
//   idu_md_valid     decode presents an M-extension op this cycle
//   idu_func3        op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   idu_addr_dst     destination register of the op
//   md_op_a/md_op_b  rs1/rs2 values after forwarding
//   md_flush         abort any op in flight (branch redirect)
//   md_stall         hold upstream stages
//   md_busy          sequencer is not idle
//   md_result_valid  one-cycle strobe qualifying md_result/md_addr_dst
//   md_result        result value
//   md_addr_dst      destination register of md_result

module ieu_muldiv_seq #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    brq_clk,
  input  logic                    brq_rst,
  input  logic                    idu_md_valid,
  input  logic [2:0]              idu_func3,
  input  logic [RegAddrWidth-1:0] idu_addr_dst,
  input  logic [DataWidth-1:0]    md_op_a,
  input  logic [DataWidth-1:0]    md_op_b,
  input  logic                    md_flush,
  output logic                    md_stall,
  output logic                    md_busy,
  output logic                    md_result_valid,
  output logic [DataWidth-1:0]    md_result,
  output logic [RegAddrWidth-1:0] md_addr_dst
);

  localparam int CntWidth = $clog2(DataWidth);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  state_e                  state_q;
  logic [1:0]              func3_q;
  logic [RegAddrWidth-1:0] dst_q;
  logic [DataWidth-1:0]    opA_q;
  logic [DataWidth-1:0]    opB_q;
  logic [DataWidth-1:0]    quo_q;
  logic [DataWidth-1:0]    rem_q;
  logic [CntWidth-1:0]     count_q;
  logic                    negQuo_q;
  logic                    negRem_q;
  logic [DataWidth-1:0]    result_q;
  logic [RegAddrWidth-1:0] addrDst_q;

  // Accept-side decode on the live decode inputs. Signed divide ops have
  // func3[0]=0; remainder ops have func3[1]=1.
  logic                 accept;
  logic                 divSigned;
  logic                 divIsRem;
  logic                 divByZero;
  logic                 divOverflow;
  logic [DataWidth-1:0] absA;
  logic [DataWidth-1:0] absB;
  logic [DataWidth-1:0] specialResult;

  always_comb begin
    accept        = (state_q == IDLE) && idu_md_valid && !md_flush;
    divSigned     = ~idu_func3[0];
    divIsRem      = idu_func3[1];
    divByZero     = (md_op_b == '0);
    divOverflow   = divSigned && (md_op_a == {1'b1, {(DataWidth-1){1'b0}}})
                    && (md_op_b == '1);
    absA          = (divSigned && md_op_a[DataWidth-1]) ? -md_op_a : md_op_a;
    absB          = (divSigned && md_op_b[DataWidth-1]) ? -md_op_b : md_op_b;
    specialResult = '0;
    if (divByZero) begin
      specialResult = divIsRem ? md_op_a : '1;
    end else begin
      specialResult = divIsRem ? '0 : {1'b1, {(DataWidth-1){1'b0}}};
    end
  end

  // Multiply datapath: operands are extended to double width according to
  // their signedness so a single truncated product covers every variant.
  logic                     mulASigned;
  logic                     mulBSigned;
  logic [2*DataWidth-1:0]   mulA;
  logic [2*DataWidth-1:0]   mulB;
  logic [2*DataWidth-1:0]   product;
  logic [DataWidth-1:0]     mulResult;

  always_comb begin
    mulASigned = (func3_q == 2'b01) || (func3_q == 2'b10);
    mulBSigned = (func3_q == 2'b01);
    mulA       = {{DataWidth{mulASigned & opA_q[DataWidth-1]}}, opA_q};
    mulB       = {{DataWidth{mulBSigned & opB_q[DataWidth-1]}}, opB_q};
    product    = mulA * mulB;
    mulResult  = (func3_q == 2'b00) ? product[DataWidth-1:0]
                                    : product[2*DataWidth-1:DataWidth];
  end

  // One restoring divide step. The shifted partial remainder needs one extra
  // bit because an unsigned divisor can use the full data width, and one more
  // bit holds the borrow that decides whether to restore.
  logic [DataWidth:0]   remShift;
  logic [DataWidth+1:0] diff;
  logic                 stepNeg;
  logic [DataWidth-1:0] remStep_d;
  logic [DataWidth-1:0] quoStep_d;
  logic [DataWidth-1:0] quoFix;
  logic [DataWidth-1:0] remFix;
  logic [DataWidth-1:0] divResult;

  always_comb begin
    remShift  = {rem_q, quo_q[DataWidth-1]};
    diff      = {1'b0, remShift} - {2'b00, opB_q};
    stepNeg   = diff[DataWidth+1];
    remStep_d = stepNeg ? remShift[DataWidth-1:0] : diff[DataWidth-1:0];
    quoStep_d = {quo_q[DataWidth-2:0], ~stepNeg};
    quoFix    = negQuo_q ? -quoStep_d : quoStep_d;
    remFix    = negRem_q ? -remStep_d : remStep_d;
    divResult = func3_q[1] ? remFix : quoFix;
  end

  // Sequencer. Flush has priority over everything but reset and simply
  // returns to IDLE, so the result registers keep their previous contents.
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q   <= IDLE;
      func3_q   <= '0;
      dst_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      addrDst_q <= '0;
    end else if (md_flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            func3_q  <= idu_func3[1:0];
            dst_q    <= idu_addr_dst;
            opA_q    <= md_op_a;
            opB_q    <= idu_func3[2] ? absB : md_op_b;
            negQuo_q <= divSigned && (md_op_a[DataWidth-1] ^ md_op_b[DataWidth-1]);
            negRem_q <= divSigned && md_op_a[DataWidth-1];
            if (!idu_func3[2]) begin
              state_q <= MUL;
            end else if (divByZero || divOverflow) begin
              result_q  <= specialResult;
              addrDst_q <= idu_addr_dst;
              state_q   <= DONE;
            end else begin
              quo_q   <= absA;
              rem_q   <= '0;
              count_q <= CntWidth'(DataWidth - 1);
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          result_q  <= mulResult;
          addrDst_q <= dst_q;
          state_q   <= DONE;
        end
        DIV: begin
          quo_q <= quoStep_d;
          rem_q <= remStep_d;
          if (count_q == '0) begin
            result_q  <= divResult;
            addrDst_q <= dst_q;
            state_q   <= DONE;
          end else begin
            count_q <= count_q - CntWidth'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The strobe is decoded from the DONE state rather than registered so that
  // a flush arriving in the DONE cycle itself can still suppress it. Stall
  // covers the accept cycle combinationally and drops during reset or flush.
  always_comb begin
    md_result_valid = (state_q == DONE) && !md_flush;
    md_busy         = (state_q != IDLE);
    md_stall        = !brq_rst && !md_flush &&
                      (accept || (state_q == MUL) || (state_q == DIV));
    md_result       = result_q;
    md_addr_dst     = addrDst_q;
  end

endmodule

// File: tb/tb_ieu_muldiv_seq.sv
// Testbench for ieu_muldiv_seq. Expected results are queued when an op is
// issued and compared when the sequencer raises its result strobe.

module tb_ieu_muldiv_seq;

  logic        clock;
  logic        reset;
  logic        mdValid;
  logic [2:0]  func3;
  logic [4:0]  addrDst;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        mdStall;
  logic        mdBusy;
  logic        resultValid;
  logic [31:0] result;
  logic [4:0]  resultDst;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  ieu_muldiv_seq #(
    .DataWidth(32),
    .RegAddrWidth(5)
  ) dut (
    .brq_clk        (clock),
    .brq_rst        (reset),
    .idu_md_valid   (mdValid),
    .idu_func3      (func3),
    .idu_addr_dst   (addrDst),
    .md_op_a        (opA),
    .md_op_b        (opB),
    .md_flush       (flush),
    .md_stall       (mdStall),
    .md_busy        (mdBusy),
    .md_result_valid(resultValid),
    .md_result      (result),
    .md_addr_dst    (resultDst)
  );

  // 10 ns clock with a free-running cycle counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    #1;
    if (resultValid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedStrobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("resultDst", resultDst, e.dst);
        checkOutput("strobeCycle", cycle, e.cyc);
      end
    end
  end

  // Issue one op for a single cycle, scramble the operand inputs afterwards,
  // and count stall cycles until the strobe (bounded).
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] dst,
                               input logic [31:0] expRes, input int expLat);
    exp_t e;
    int   stallCnt;
    bit   seen;
    @(negedge clock);
    mdValid = 1'b1;
    func3   = f3;
    opA     = a;
    opB     = b;
    addrDst = dst;
    e.res   = expRes;
    e.dst   = dst;
    e.cyc   = cycle + expLat;
    sb.push_back(e);
    #1;
    stallCnt = (mdStall === 1'b1) ? 1 : 0;
    seen     = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      mdValid = 1'b0;
      func3   = 3'($urandom);
      opA     = $urandom;
      opB     = $urandom;
      addrDst = 5'($urandom);
      #1;
      if (resultValid === 1'b1) begin
        seen = 1'b1;
        checkOutput("stallAtStrobe", mdStall, 0);
      end else if (mdStall === 1'b1) begin
        stallCnt++;
      end
    end
    checkOutput("strobeSeen", seen, 1);
    checkOutput("stallCycles", stallCnt, expLat);
  endtask

  initial begin
    reset   = 1'b1;
    mdValid = 1'b0;
    func3   = 3'b000;
    addrDst = 5'd0;
    opA     = 32'd0;
    opB     = 32'd0;
    flush   = 1'b0;

    #2;
    checkOutput("rstResult", result, 0);
    checkOutput("rstValid", resultValid, 0);
    checkOutput("rstBusy", mdBusy, 0);
    checkOutput("rstStall", mdStall, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    $display("[TB] reset released");

    // Multiply variants.
    applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, 2);
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 2);
    applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 2);
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 2);
    applyStimulus(3'b001, 32'h80000000, 32'h00000002, 5'd4, 32'hFFFFFFFF, 2);

    // Iterative divide/remainder.
    applyStimulus(3'b100, 32'hFFFFFFEC, 32'd3, 5'd5, 32'hFFFFFFFA, 33);
    applyStimulus(3'b110, 32'hFFFFFFEC, 32'd3, 5'd6, 32'hFFFFFFFE, 33);
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    applyStimulus(3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd10, 32'd1, 33);
    applyStimulus(3'b100, 32'd50, 32'hFFFFFFF9, 5'd11, 32'hFFFFFFF9, 33);

    // Special cases finish straight from the accept cycle.
    applyStimulus(3'b101, 32'd100, 32'd0, 5'd12, 32'hFFFFFFFF, 1);
    applyStimulus(3'b111, 32'd100, 32'd0, 5'd13, 32'd100, 1);
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 1);

    // Flush a divide in flight: no strobe may follow, result is untouched.
    @(negedge clock);
    mdValid = 1'b1;
    func3   = 3'b101;
    opA     = 32'd1000;
    opB     = 32'd3;
    addrDst = 5'd20;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      mdValid = 1'b0;
    end
    flush = 1'b1;
    #1;
    checkOutput("flushStall", mdStall, 0);
    checkOutput("flushValid", resultValid, 0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    checkOutput("flushBusy", mdBusy, 0);
    checkOutput("flushStallAfter", mdStall, 0);
    checkOutput("flushResultKept", result, 32'd0);
    repeat (40) @(negedge clock);
    checkOutput("flushStaysIdle", mdBusy, 0);

    applyStimulus(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 2);

    // Asynchronous reset between clock edges in the middle of a divide.
    @(negedge clock);
    mdValid = 1'b1;
    func3   = 3'b100;
    opA     = 32'd77;
    opB     = 32'd5;
    addrDst = 5'd22;
    @(negedge clock);
    mdValid = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstResult", result, 0);
    checkOutput("asyncRstDst", resultDst, 0);
    checkOutput("asyncRstValid", resultValid, 0);
    checkOutput("asyncRstBusy", mdBusy, 0);
    checkOutput("asyncRstStall", mdStall, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      checkOutput("postRstBusy", mdBusy, 0);
      checkOutput("postRstStall", mdStall, 0);
    end

    repeat (5) @(negedge clock);
    checkOutput("scoreboardEmpty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
